// File: rtl/seven_seg_scan_ctrl.sv
// Multiplexed 7-seg scanner: one registered stage from scan state to pins; single-entry input buffer, din_ready low while full.
// Optional leading-zero blanking under SEVEN_SEG_LZB_EN; the pending value is swapped into the display only at frame boundaries.
package seven_seg_pkg;
    typedef logic [6:0] seven_seg_t;    // {g,f,e,d,c,b,a}, active-high
endpackage

module seven_seg (
    input  logic [3:0]                hex,
    output seven_seg_pkg::seven_seg_t seg
);
    always_comb begin
        seg = '0;
        case (hex)
            4'h0: seg = 7'h3F;
            4'h1: seg = 7'h06;
            4'h2: seg = 7'h5B;
            4'h3: seg = 7'h4F;
            4'h4: seg = 7'h66;
            4'h5: seg = 7'h6D;
            4'h6: seg = 7'h7D;
            4'h7: seg = 7'h07;
            4'h8: seg = 7'h7F;
            4'h9: seg = 7'h6F;
            4'hA: seg = 7'h77;
            4'hB: seg = 7'h7C;
            4'hC: seg = 7'h39;
            4'hD: seg = 7'h5E;
            4'hE: seg = 7'h79;
            4'hF: seg = 7'h71;
            default: seg = '0;
        endcase
    end
endmodule

module seven_seg_scan_ctrl #(
    parameter int DIGIT_COUNT  = 4,
    parameter int DWELL_CYCLES = 1000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [4*DIGIT_COUNT-1:0]   din,
    input  logic                       din_valid,
    output logic                       din_ready,
    output seven_seg_pkg::seven_seg_t  dout,
    output logic [DIGIT_COUNT-1:0]     digit_en,
    output logic                       frame_done
);
    localparam int CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int IDX_W   = (DIGIT_COUNT > 1) ? $clog2(DIGIT_COUNT) : 1;
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DIGIT_COUNT - 1);
    localparam bit               NO_BLANK   = (BLANK_CYCLES == 0);

    typedef enum logic {BLANK, SHOW} state_t;

    state_t                     state, state_nxt;
    logic [CNT_W-1:0]           cnt, cnt_nxt;
    logic [IDX_W-1:0]           digit_idx, idx_nxt;
    logic [4*DIGIT_COUNT-1:0]   pending, active;
    logic                       pending_full;
    logic                       wrap, show, lz_blank;
    logic [3:0]                 nibble;
    logic [DIGIT_COUNT-1:0]     digit_sel;
    seven_seg_pkg::seven_seg_t  seg;

    assign din_ready = !pending_full;

    // With no blanking gap the reset BLANK state already behaves as SHOW.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + 1'b1;
        idx_nxt   = digit_idx;
        wrap      = 1'b0;
        show      = (state == SHOW) || NO_BLANK;
        if (show) begin
            if (cnt == DWELL_LAST) begin
                cnt_nxt   = '0;
                wrap      = (digit_idx == IDX_LAST);
                idx_nxt   = wrap ? '0 : digit_idx + 1'b1;
                state_nxt = NO_BLANK ? SHOW : BLANK;
            end
        end else if (cnt == BLANK_LAST) begin
            cnt_nxt   = '0;
            state_nxt = SHOW;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= BLANK;
            cnt       <= '0;
            digit_idx <= '0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            digit_idx <= idx_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending      <= '0;
            pending_full <= 1'b0;
            active       <= '0;
        end else if (wrap && pending_full) begin
            active       <= pending;
            pending_full <= 1'b0;
        end else if (din_valid && !pending_full) begin
            pending      <= din;
            pending_full <= 1'b1;
        end
    end

    assign nibble = active[4*digit_idx +: 4];

    seven_seg u_dec (
        .hex (nibble),
        .seg (seg)
    );

    always_comb begin
        digit_sel = '0;
        for (int i = 0; i < DIGIT_COUNT; i++) begin
            digit_sel[i] = show && (digit_idx == IDX_W'(i));
        end
`ifdef SEVEN_SEG_LZB_EN
        lz_blank = (digit_idx != '0) && ((active >> (4*digit_idx)) == '0);
`else
        lz_blank = 1'b0;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout       <= '0;
            digit_en   <= '0;
            frame_done <= 1'b0;
        end else begin
            dout       <= (show && !lz_blank) ? seg : '0;
            digit_en   <= digit_sel;
            frame_done <= wrap;
        end
    end
endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Directed bench: 4-digit scanner (dwell 4, blank 2) plus a 1-digit no-gap instance sharing clock and reset.
module tb_seven_seg_scan_ctrl;
`ifdef SEVEN_SEG_LZB_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    logic                      clk = 1'b0;
    logic                      rst_n;
    logic [15:0]               din;
    logic                      din_valid;
    logic                      din_ready;
    seven_seg_pkg::seven_seg_t dout;
    logic [3:0]                digit_en;
    logic                      frame_done;

    logic                      din_ready1;
    seven_seg_pkg::seven_seg_t dout1;
    logic [0:0]                digit_en1;
    logic                      frame_done1;

    int checks = 0;
    int failures = 0;
    int k = 0;

    always #5 clk = ~clk;

    seven_seg_scan_ctrl #(.DIGIT_COUNT(4), .DWELL_CYCLES(4), .BLANK_CYCLES(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .dout       (dout),
        .digit_en   (digit_en),
        .frame_done (frame_done)
    );

    seven_seg_scan_ctrl #(.DIGIT_COUNT(1), .DWELL_CYCLES(4), .BLANK_CYCLES(0)) dut1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (4'h0),
        .din_valid  (1'b0),
        .din_ready  (din_ready1),
        .dout       (dout1),
        .digit_en   (digit_en1),
        .frame_done (frame_done1)
    );

    function automatic logic [6:0] seg_ref(input logic [3:0] n);
        case (n)
            4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
            4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
            4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
            4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, exp, k);
        end
    endtask

    // One clock, then compare both instances against the scan-timing model for value `shown`.
    task automatic tick_chk(input logic [15:0] shown);
        int         pos;
        int         dg;
        logic [3:0] nib;
        logic [3:0] en_exp;
        logic [6:0] dout_exp;
        logic       lz;
        @(posedge clk);
        #1;
        k++;
        pos = (k - 1) % 6;
        dg  = ((k - 1) / 6) % 4;
        nib = shown[4*dg +: 4];
        lz  = (dg > 0) && ((shown >> (4*dg)) == 16'h0);
        en_exp   = (pos >= 2) ? 4'(1 << dg) : 4'h0;
        dout_exp = ((pos >= 2) && !(LZB && lz)) ? seg_ref(nib) : 7'h00;
        chk("digit_en", 32'(digit_en), 32'(en_exp));
        chk("dout", 32'(dout), 32'(dout_exp));
        chk("frame_done", 32'(frame_done), 32'(k % 24 == 0));
        chk("digit_en_1d", 32'(digit_en1), 32'd1);
        chk("dout_1d", 32'(dout1), 32'h3F);
        chk("frame_done_1d", 32'(frame_done1), 32'(k % 4 == 0));
    endtask

    initial begin
        rst_n = 1'b0;
        din = 16'h0;
        din_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_dout", 32'(dout), 32'h0);
        chk("rst_digit_en", 32'(digit_en), 32'h0);
        chk("rst_frame_done", 32'(frame_done), 32'h0);
        chk("rst_din_ready", 32'(din_ready), 32'h1);
        chk("rst_digit_en_1d", 32'(digit_en1), 32'h0);
        rst_n = 1'b1;

        repeat (24) tick_chk(16'h0000);

        repeat (6) tick_chk(16'h0000);
        din = 16'h1A3F;
        din_valid = 1'b1;
        chk("ready_before_load", 32'(din_ready), 32'h1);
        tick_chk(16'h0000);
        din_valid = 1'b0;
        chk("ready_after_load", 32'(din_ready), 32'h0);
        repeat (16) tick_chk(16'h0000);
        chk("ready_before_boundary", 32'(din_ready), 32'h0);
        tick_chk(16'h0000);
        chk("ready_after_boundary", 32'(din_ready), 32'h1);

        repeat (2) tick_chk(16'h1A3F);
        din = 16'h1111;
        din_valid = 1'b1;
        tick_chk(16'h1A3F);
        chk("bp_first_accepted", 32'(din_ready), 32'h0);
        din = 16'h2222;
        repeat (20) tick_chk(16'h1A3F);
        chk("bp_stall", 32'(din_ready), 32'h0);
        tick_chk(16'h1A3F);
        chk("bp_release", 32'(din_ready), 32'h1);
        tick_chk(16'h1111);
        chk("bp_second_accepted", 32'(din_ready), 32'h0);
        din_valid = 1'b0;
        repeat (23) tick_chk(16'h1111);

        repeat (2) tick_chk(16'h2222);
        din = 16'h3333;
        din_valid = 1'b1;
        tick_chk(16'h2222);
        din_valid = 1'b0;
        chk("pending_before_reset", 32'(din_ready), 32'h0);
        repeat (13) tick_chk(16'h2222);
        chk("mid_frame_digit2", 32'(digit_en), 32'h4);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst_dout", 32'(dout), 32'h0);
        chk("async_rst_digit_en", 32'(digit_en), 32'h0);
        chk("async_rst_frame_done", 32'(frame_done), 32'h0);
        chk("async_rst_din_ready", 32'(din_ready), 32'h1);
        repeat (3) @(posedge clk);
        #1;
        chk("held_rst_digit_en", 32'(digit_en), 32'h0);
        rst_n = 1'b1;
        k = 0;

        repeat (4) tick_chk(16'h0000);
        din = 16'h0050;
        din_valid = 1'b1;
        tick_chk(16'h0000);
        din_valid = 1'b0;
        repeat (19) tick_chk(16'h0000);
        repeat (24) tick_chk(16'h0050);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/seven_seg_scan_ctrl.md
# seven_seg_scan_ctrl

Time-multiplexed scan controller for a common-segment multi-digit seven-segment display. Buffers a packed hex value through a valid/ready handshake, steps one digit at a time through the existing `seven_seg` decoder, and drives one-hot digit enables with a blanking gap between digits to suppress ghosting. Sits between the value-producing logic and the display pins.

## Interface
- `DIGIT_COUNT`, 4: number of digits; legal range 1..8.
- `DWELL_CYCLES`, 1000: clocks each digit is lit; must be ≥1.
- `BLANK_CYCLES`, 16: clocks all digits are off before each digit is lit; 0 means no gap.
- `clk`  in  1  clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `din`  in  4*DIGIT_COUNT  packed nibbles; digit i is `din[4i+3:4i]`, and digit 0 is least significant.
- `din_valid`  in  1  `din` offered.
- `din_ready`  out  1  pending buffer empty; a transfer occurs when `din_valid && din_ready`.
- `dout`  out  seven_seg_pkg::seven_seg_t  segment pattern, registered; active-high segments; blank is `'0`.
- `digit_en`  out  DIGIT_COUNT  one-hot digit enable, registered, active-high; all zero while blanking.
- `frame_done`  out  1  one-cycle pulse at the end of the last digit's dwell.

## Operation
- Registers:
  - `pending` and `pending_full`.
  - `active`, the value currently displayed.
  - `digit_idx`, range 0..DIGIT_COUNT-1.
  - `state`, one of BLANK or SHOW.
  - `cnt`, width $clog2(max(DWELL_CYCLES,BLANK_CYCLES)+1).
- Input buffer:
  - `din_ready = !pending_full`; this is a pure function of the register.
  - On transfer: `pending <= din`, `pending_full <= 1`.
- Frame boundary: the transition out of SHOW for digit DIGIT_COUNT-1.
  - If `pending_full`: `active <= pending`, `pending_full <= 0`.
  - `din_ready` is still low in that cycle, so no transfer can coincide with the copy.
- State machine:
  - BLANK: `digit_en = 0`, `dout = '0`. Lasts BLANK_CYCLES clocks, then goes to SHOW with `cnt` reloaded.
  - BLANK_CYCLES = 0: BLANK is skipped entirely; SHOW follows SHOW directly.
  - SHOW: `digit_en = 1 << digit_idx`, `dout = seven_seg(active nibble digit_idx)`. Lasts DWELL_CYCLES clocks.
  - On leaving SHOW: `digit_idx` increments, wrapping DIGIT_COUNT-1 → 0, then go to BLANK (or SHOW if BLANK_CYCLES = 0).
  - The wrap cycle raises `frame_done` for exactly one clock.
- Decoding: one `seven_seg` instance, fed by a mux that selects the `active` nibble at `digit_idx`. The decoder output is registered into `dout` together with `digit_en`.
- Values are never torn: `active` changes only at a frame boundary, so every frame shows a single coherent value.

## Timing
- Reset values:
  - `dout = '0`, `digit_en = 0`, `frame_done = 0`, `din_ready = 1`.
  - `state = BLANK`, `digit_idx = 0`, `cnt = 0`, `active = 0`, `pending_full = 0`.
- Reset asserted mid-frame returns everything to reset values immediately; any pending data is discarded.
- First lit digit after reset release: digit 0 showing `0`, starting BLANK_CYCLES clocks after the first edge.
- Frame period: DIGIT_COUNT × (DWELL_CYCLES + BLANK_CYCLES) clocks.
- Input-to-display latency: a value accepted at any point is first visible at digit 0 of the next frame. Worst case is one frame period plus BLANK_CYCLES.
- `din_ready` back-pressure:
  - A second value offered while `pending_full` stalls until the frame boundary.
  - `din_ready` returns high on the clock after the boundary.
- `dout` and `digit_en` change on the same edge. Digit-to-digit transitions always pass through an all-off state when BLANK_CYCLES > 0.
- DIGIT_COUNT = 1: `digit_idx` stays 0, and `frame_done` pulses after every dwell.

## Configuration
- `SEVEN_SEG_LZB_EN` (leading-zero blanking):
  - Defined: in SHOW, a digit i > 0 whose nibble is 0 and whose more-significant digits are all 0 is driven with `dout = '0`. Its `digit_en` is still asserted, so scan timing is unchanged. Digit 0 is never blanked.
  - Undefined: every digit is decoded, including leading zeros.

## Test plan
Unless stated otherwise, benches use DIGIT_COUNT=4, DWELL_CYCLES=4, BLANK_CYCLES=2.
- Reset: hold `rst_n` low for 3 clocks, then release.
  - Outputs hold reset values.
  - Then 2 clocks with `digit_en = 0`, then `digit_en = 4'b0001` with `dout = seven_seg(0)` for 4 clocks.
  - `frame_done` first pulses at clock 24.
- Load: transfer `din = 16'h1A3F` mid-frame.
  - `din_ready` drops the next clock.
  - The next frame shows F, 3, A, 1 on `digit_en` 0001, 0010, 0100, 1000.
  - `din_ready` rises the clock after the boundary.
- Back-pressure: offer 16'h1111, then 16'h2222 with `din_valid` held.
  - 16'h2222 is accepted only after the boundary that loads 16'h1111.
  - Each value is displayed for whole frames only.
- Reset mid-frame: pull `rst_n` low during SHOW of digit 2 with `pending_full = 1`.
  - Outputs go to reset values asynchronously and `din_ready = 1`.
  - After release, the display shows 0000.
- BLANK_CYCLES=0, DIGIT_COUNT=1: `digit_en` is constantly 1 and `frame_done` pulses every 4 clocks.
- `SEVEN_SEG_LZB_EN` defined, `din = 16'h0050`:
  - Digits 0 and 1 are decoded; digits 2 and 3 show `dout = '0` with their enables still asserted.
  - With the macro undefined, digits 2 and 3 show `seven_seg(0)`.
